// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: dump FSM state encoding
// and the default geometry / hardwired-zero register index.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  localparam int DEFAULT_NB_ADDR = 5;
  localparam int DEFAULT_DEPTH   = 2 ** DEFAULT_NB_ADDR;
  localparam int R0_ADDR         = 0;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Sequential dump engine: walks register indices 0..2**NB_ADDR-1 over a
// valid/ready channel, then pulses done for one cycle.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int NB_ADDR = DEFAULT_NB_ADDR
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [NB_ADDR-1:0] o_addr,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};

  dump_state_t        r_state;
  logic [NB_ADDR-1:0] r_addr;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  // Async reset aborts a dump in flight without emitting a done pulse.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= RUN;
            r_addr  <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (r_valid && i_ready) begin
            if (r_addr == LAST_ADDR) begin
              r_state <= DONE;
              r_addr  <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_addr  <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port MIPS register file (N read, 2 write, r0 = 0) with a register dump port.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR     = DEFAULT_NB_ADDR,
  parameter int NB_RD_PORTS = 2,
  parameter int NB_WR_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic [NB_WR_PORTS-1:0]         i_we,
  input  logic [NB_WR_PORTS*NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_WR_PORTS*NB_DATA-1:0] i_wr_data,
  input  logic [NB_RD_PORTS*NB_ADDR-1:0] i_rd_addr,
  output logic [NB_RD_PORTS*NB_DATA-1:0] o_rd_data,
  output logic                           o_wr_conflict,
  input  logic                           i_dump_start,
  input  logic                           i_dump_ready,
  output logic                           o_dump_valid,
  output logic [NB_ADDR-1:0]             o_dump_addr,
  output logic [NB_DATA-1:0]             o_dump_data,
  output logic                           o_dump_busy,
  output logic                           o_dump_done
);

  localparam int                 DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_ADDR-1:0] ZERO  = NB_ADDR'(R0_ADDR);

  logic [NB_DATA-1:0] r_regs [DEPTH];
  logic               r_wr_conflict;

  logic [NB_ADDR-1:0] w_wa [NB_WR_PORTS];
  logic [NB_DATA-1:0] w_wd [NB_WR_PORTS];
  logic [NB_ADDR-1:0] w_ra [NB_RD_PORTS];
  logic [NB_DATA-1:0] w_rd [NB_RD_PORTS];
  logic               w_conflict;

  always_comb begin
    for (int k = 0; k < NB_WR_PORTS; k++) begin
      w_wa[k] = i_wr_addr[k*NB_ADDR +: NB_ADDR];
      w_wd[k] = i_wr_data[k*NB_DATA +: NB_DATA];
    end
  end

  // Ascending port order: the last (highest) port's assignment wins on a tie.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int k = 0; k < NB_WR_PORTS; k++) begin
        if (i_we[k] && (w_wa[k] != ZERO)) r_regs[w_wa[k]] <= w_wd[k];
      end
    end
  end

  assign w_conflict = i_we[0] && i_we[1] && (w_wa[0] == w_wa[1]) && (w_wa[0] != ZERO);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_wr_conflict <= 1'b0;
    else          r_wr_conflict <= w_conflict;
  end

  assign o_wr_conflict = r_wr_conflict;

  always_comb begin
    for (int p = 0; p < NB_RD_PORTS; p++) begin
      w_ra[p] = i_rd_addr[p*NB_ADDR +: NB_ADDR];
      w_rd[p] = (w_ra[p] == ZERO) ? '0 : r_regs[w_ra[p]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NB_WR_PORTS; k++) begin
        if (i_we[k] && (w_wa[k] != ZERO) && (w_wa[k] == w_ra[p])) w_rd[p] = w_wd[k];
      end
`endif
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int p = 0; p < NB_RD_PORTS; p++) o_rd_data[p*NB_DATA +: NB_DATA] = w_rd[p];
  end

  regfile_dump_fsm #(
    .NB_ADDR (NB_ADDR)
  ) u_dump_fsm (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_start (i_dump_start),
    .i_ready (i_dump_ready),
    .o_valid (o_dump_valid),
    .o_addr  (o_dump_addr),
    .o_busy  (o_dump_busy),
    .o_done  (o_dump_done)
  );

  // Dump reads the stored array only; in-flight writes are never forwarded here.
  assign o_dump_data = (o_dump_addr == ZERO) ? '0 : r_regs[o_dump_addr];

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp against an array-based reference model.
// Honours REGFILE_BYPASS_EN when the same macro is defined for the build.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk;
  logic             rst_n;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             wr_conflict;
  logic             dump_start;
  logic             dump_ready;
  logic             dump_valid;
  logic [AW-1:0]    dump_addr;
  logic [DW-1:0]    dump_data;
  logic             dump_busy;
  logic             dump_done;

  int          vec;
  int          errs;
  logic [31:0] model [32];
  logic        exp_conf;

  register_file_mp #(
    .NB_DATA(DW), .NB_ADDR(AW), .NB_RD_PORTS(NR), .NB_WR_PORTS(NW)
  ) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_we          (we),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_wr_conflict (wr_conflict),
    .i_dump_start  (dump_start),
    .i_dump_ready  (dump_ready),
    .o_dump_valid  (dump_valid),
    .o_dump_addr   (dump_addr),
    .o_dump_data   (dump_data),
    .o_dump_busy   (dump_busy),
    .o_dump_done   (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : model[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 5'd0 && we[0] && wr_addr[4:0] == a) v = wr_data[31:0];
    if (a != 5'd0 && we[1] && wr_addr[9:5] == a) v = wr_data[63:32];
`endif
    return v;
  endfunction

  // Advance one clock; the model absorbs the writes presented in this cycle.
  task automatic tick();
    logic c;
    c = we[0] && we[1] && (wr_addr[4:0] == wr_addr[9:5]) && (wr_addr[4:0] != 5'd0);
    for (int k = 0; k < NW; k++)
      if (we[k] && wr_addr[k*AW +: AW] != 5'd0) model[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
    @(posedge clk);
    #1;
    exp_conf = c;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    exp_conf = 1'b0;
  endtask

  task automatic check_reads(input string tag);
    for (int p = 0; p < NR; p++) begin
      vec++;
      if (rd_data[p*DW +: DW] !== exp_rd(rd_addr[p*AW +: AW])) begin
        errs++;
        $display("FAIL %s port%0d addr=%0d got=%h exp=%h", tag, p, rd_addr[p*AW +: AW],
                 rd_data[p*DW +: DW], exp_rd(rd_addr[p*AW +: AW]));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = '0; wr_addr = '0; wr_data = '0; rd_addr = {5'd5, 5'd5};
    dump_start = 1'b0; dump_ready = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_reads("reset_rd");
    vec++;
    if ({wr_conflict, dump_valid, dump_busy, dump_done, dump_addr, dump_data} !== '0) begin
      errs++;
      $display("FAIL reset_outs got c=%b v=%b b=%b d=%b a=%0d data=%h exp all zero",
               wr_conflict, dump_valid, dump_busy, dump_done, dump_addr, dump_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    we = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
    tick();
    we = '0; rd_addr = {5'd5, 5'd5};
    #1;
    check_reads("wr_rd_r5");
    vec++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL r5_const got=%h exp=deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_r0();
    we = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'h1234, 32'h1234};
    tick();
    we = '0; rd_addr = {5'd0, 5'd0};
    #1;
    check_reads("r0_read");
    vec++;
    if (wr_conflict !== 1'b0) begin
      errs++;
      $display("FAIL r0_conflict got=%b exp=0", wr_conflict);
    end
  endtask

  task automatic test_conflict();
    we = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    tick();
    we = '0; rd_addr = {5'd7, 5'd7};
    #1;
    vec++;
    if (wr_conflict !== 1'b1 || rd_data[31:0] !== 32'h22) begin
      errs++;
      $display("FAIL conflict got c=%b r7=%h exp c=1 r7=00000022", wr_conflict, rd_data[31:0]);
    end
    tick();
    vec++;
    if (wr_conflict !== 1'b0) begin
      errs++;
      $display("FAIL conflict_pulse got=%b exp=0", wr_conflict);
    end
  endtask

  task automatic test_same_cycle();
    we = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'hA5A5A5A5}; rd_addr = {5'd3, 5'd3};
    #1;
    check_reads("same_cycle");
    vec++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data[31:0] !== 32'hA5A5A5A5) begin
      errs++;
      $display("FAIL bypass got=%h exp=a5a5a5a5", rd_data[31:0]);
    end
`else
    if (rd_data[31:0] !== 32'd0) begin
      errs++;
      $display("FAIL no_bypass got=%h exp=00000000", rd_data[31:0]);
    end
`endif
    tick();
    we = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      we      = 2'($urandom_range(0, 3));
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      #1;
      check_reads("rand_rd");
      tick();
      vec++;
      if (wr_conflict !== exp_conf) begin
        errs++;
        $display("FAIL rand_conflict n=%0d got=%b exp=%b", n, wr_conflict, exp_conf);
      end
    end
    we = '0;
  endtask

  task automatic test_dump();
    for (int i = 1; i < 32; i += 2) begin
      we = (i == 31) ? 2'b01 : 2'b11;
      wr_addr = {5'(i + 1), 5'(i)};
      wr_data = {32'(i + 1), 32'(i)};
      tick();
    end
    we = '0; dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dump_start = (i == 5);
      #1;
      vec++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_addr !== 5'(i) ||
          dump_data !== 32'(i) || dump_done !== 1'b0) begin
        errs++;
        $display("FAIL dump_beat i=%0d got v=%b b=%b a=%0d d=%h done=%b exp v=1 b=1 a=%0d d=%h done=0",
                 i, dump_valid, dump_busy, dump_addr, dump_data, dump_done, i, i);
      end
      tick();
    end
    dump_start = 1'b0;
    vec++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
      errs++;
      $display("FAIL dump_done got done=%b v=%b b=%b exp done=1 v=0 b=0", dump_done, dump_valid, dump_busy);
    end
    tick();
    vec++;
    if (dump_done !== 1'b0 || dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
      errs++;
      $display("FAIL dump_idle got done=%b v=%b b=%b exp all 0", dump_done, dump_valid, dump_busy);
    end
  endtask

  task automatic test_backpressure();
    int exp_a;
    int cyc;
    exp_a = 0; cyc = 0;
    dump_start = 1'b1; dump_ready = 1'b0;
    tick();
    dump_start = 1'b0;
    while (exp_a < 32 && cyc < 400) begin
      dump_ready = 1'($urandom_range(0, 1));
      we         = 2'($urandom_range(0, 3));
      wr_addr    = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      wr_data    = {$urandom, $urandom};
      #1;
      vec++;
      if (dump_valid !== 1'b1 || dump_addr !== 5'(exp_a) ||
          dump_data !== ((exp_a == 0) ? 32'd0 : model[exp_a])) begin
        errs++;
        $display("FAIL bp_beat cyc=%0d got v=%b a=%0d d=%h exp v=1 a=%0d d=%h", cyc, dump_valid,
                 dump_addr, dump_data, exp_a, (exp_a == 0) ? 32'd0 : model[exp_a]);
      end
      if (dump_ready) exp_a++;
      tick();
      cyc++;
    end
    we = '0;
    vec++;
    if (exp_a != 32) begin
      errs++;
      $display("FAIL bp_timeout beats=%0d exp=32", exp_a);
    end
    vec++;
    if (dump_done !== 1'b1 || dump_busy !== 1'b0) begin
      errs++;
      $display("FAIL bp_done got done=%b b=%b exp done=1 b=0", dump_done, dump_busy);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (10) tick();
    vec++;
    if (dump_addr !== 5'd10 || dump_valid !== 1'b1) begin
      errs++;
      $display("FAIL abort_pre got a=%0d v=%b exp a=10 v=1", dump_addr, dump_valid);
    end
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    rd_addr = {5'd10, 5'd7};
    #1;
    vec++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || dump_addr !== 5'd0) begin
      errs++;
      $display("FAIL abort_outs got v=%b b=%b done=%b a=%0d exp all 0", dump_valid, dump_busy, dump_done, dump_addr);
    end
    check_reads("abort_rd");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
        errs++;
        $display("FAIL abort_post i=%0d got done=%b v=%b b=%b exp all 0", i, dump_done, dump_valid, dump_busy);
      end
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_write_read();
    test_r0();
    test_conflict();
    test_same_cycle();
    test_random();
    test_dump();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
